// File: rtl/fpu_add_sequencer_if.sv
// fpu_add_sequencer_if: operand/result handshakes and datapath control bundle for the adder sequencer
interface fpu_add_sequencer_if #(parameter int LAT_W = 8);
    logic             in_valid;
    logic             in_ready;
    logic             op_load;
    logic [3:0]       special_next;
    logic             align_done;
    logic             norm_done;
    logic [3:0]       state;
    logic             z_sel_special;
    logic             out_valid;
    logic             out_ready;
    logic [LAT_W-1:0] last_latency;
    logic             guard_err;

    modport master (
        output in_valid, special_next, align_done, norm_done, out_ready,
        input  in_ready, op_load, state, z_sel_special, out_valid, last_latency, guard_err
    );

    modport slave (
        input  in_valid, special_next, align_done, norm_done, out_ready,
        output in_ready, op_load, state, z_sel_special, out_valid, last_latency, guard_err
    );
endinterface

// File: rtl/fpu_add_sequencer.sv
// fpu_add_sequencer: control FSM for the multi-cycle single-precision adder datapath
module fpu_add_sequencer #(
    parameter int MAX_ALIGN = 27,
    parameter int MAX_NORM  = 27,
    parameter int LAT_W     = 8
) (
    input logic                clk,
    input logic                rst,
    fpu_add_sequencer_if.slave bus
);
    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] UNPACK  = 4'd1;
    localparam logic [3:0] SPECIAL = 4'd2;
    localparam logic [3:0] ALIGN   = 4'd4;
    localparam logic [3:0] ADD_0   = 4'd5;
    localparam logic [3:0] ADD_1   = 4'd6;
    localparam logic [3:0] NORM_1  = 4'd7;
    localparam logic [3:0] NORM_2  = 4'd8;
    localparam logic [3:0] ROUND   = 4'd9;
    localparam logic [3:0] PACK    = 4'd10;
    localparam logic [3:0] PUT_Z   = 4'd11;
    localparam int LOOP_W = $clog2((MAX_ALIGN > MAX_NORM ? MAX_ALIGN : MAX_NORM) + 1);

    logic [3:0]        state;
    logic [3:0]        state_nx;
    logic              spec_2nd;
    logic              z_sel;
    logic              guard;
    logic [LOOP_W-1:0] loop_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [LAT_W-1:0]  lat_next;
    logic [LAT_W-1:0]  last_lat;
    logic              accept;
    logic              go_put_z;
    logic              align_trip;
    logic              norm_trip;
    logic              handshake;
    logic              looping;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = bus.in_valid ? UNPACK : IDLE;
            UNPACK:  state_nx = SPECIAL;
            SPECIAL: state_nx = !spec_2nd ? SPECIAL : (go_put_z ? PUT_Z : ALIGN);
            ALIGN:   state_nx = (bus.align_done || align_trip) ? ADD_0 : ALIGN;
            ADD_0:   state_nx = ADD_1;
            ADD_1:   state_nx = NORM_1;
            NORM_1:  state_nx = (bus.norm_done || norm_trip) ? NORM_2 : NORM_1;
            NORM_2:  state_nx = ROUND;
            ROUND:   state_nx = PACK;
            PACK:    state_nx = PUT_Z;
            PUT_Z:   state_nx = bus.out_ready ? IDLE : PUT_Z;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        accept             = (state == IDLE) && bus.in_valid;
        go_put_z           = (state == SPECIAL) && spec_2nd && (bus.special_next == PUT_Z);
        align_trip         = (state == ALIGN) && !bus.align_done && (loop_cnt == LOOP_W'(MAX_ALIGN - 1));
        norm_trip          = (state == NORM_1) && !bus.norm_done && (loop_cnt == LOOP_W'(MAX_NORM - 1));
        handshake          = (state == PUT_Z) && bus.out_ready;
        looping            = (state_nx == state) && ((state == ALIGN) || (state == NORM_1));
        lat_next           = &lat_cnt ? lat_cnt : lat_cnt + LAT_W'(1);
        bus.in_ready       = (state == IDLE);
        bus.op_load        = accept;
        bus.out_valid      = (state == PUT_Z);
        bus.state          = state;
        bus.z_sel_special  = z_sel;
        bus.last_latency   = last_lat;
        bus.guard_err      = guard;
    end

    // Loop counter is shared by ALIGN and NORM_1; it clears on every exit from either loop.
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_2nd <= 1'b0;
            z_sel    <= 1'b0;
            guard    <= 1'b0;
            loop_cnt <= '0;
            lat_cnt  <= '0;
            last_lat <= '0;
        end else begin
            spec_2nd <= (state == SPECIAL) && !spec_2nd;
            z_sel    <= accept ? 1'b0 : (go_put_z ? 1'b1 : z_sel);
            guard    <= guard || align_trip || norm_trip;
            loop_cnt <= looping ? loop_cnt + LOOP_W'(1) : '0;
            lat_cnt  <= (state == IDLE) ? '0 : lat_next;
            last_lat <= handshake ? lat_next : last_lat;
        end
    end
endmodule

// File: tb/tb_fpu_add_sequencer.sv
// tb_fpu_add_sequencer: randomized scoreboard bench; expected state trace and results come from an op-level model
module tb_fpu_add_sequencer;
    localparam int LAT_W   = 8;
    localparam int MAXL    = 27;
    localparam int LAT_MAX = (1 << LAT_W) - 1;

    typedef struct {
        int lat;
        bit zsel;
        bit guard;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    op_t  exp_ops[$];
    int   exp_states[$];
    int   n_chk = 0;
    int   n_pass = 0;
    bit   exp_guard = 1'b0;
    bit   in_op = 1'b0;

    always #5 clk = ~clk;

    fpu_add_sequencer_if #(.LAT_W(LAT_W)) bus ();

    fpu_add_sequencer #(.MAX_ALIGN(MAXL), .MAX_NORM(MAXL), .LAT_W(LAT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // rst as seen by the edge that produced the state observed at the following negedge
    always @(posedge clk) rst_q <= rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] rnd_non11();
        logic [3:0] r;
        r = 4'($urandom_range(0, 14));
        return (r >= 4'd11) ? r + 4'd1 : r;
    endfunction

    // Op-level model: visible states in order, latency = number of non-IDLE cycles.
    function automatic void expect_op(input bit sp, input int ad, input int nd, input int od);
        int len;
        int na;
        int nn;
        exp_states.push_back(1);
        exp_states.push_back(2);
        exp_states.push_back(2);
        len = 3;
        if (!sp) begin
            na = (ad < MAXL) ? ad + 1 : MAXL;
            nn = (nd < MAXL) ? nd + 1 : MAXL;
            repeat (na) exp_states.push_back(4);
            exp_states.push_back(5);
            exp_states.push_back(6);
            repeat (nn) exp_states.push_back(7);
            exp_states.push_back(8);
            exp_states.push_back(9);
            exp_states.push_back(10);
            len += na + nn + 5;
            if (ad >= MAXL || nd >= MAXL) exp_guard = 1'b1;
        end
        repeat (od + 1) exp_states.push_back(11);
        len += od + 1;
        exp_ops.push_back('{lat: (len > LAT_MAX) ? LAT_MAX : len, zsel: sp, guard: exp_guard});
    endfunction

    // sp: special path; ad/nd: cycles align_done/norm_done held low; od: out_ready low cycles;
    // rst_at: nonzero aborts the op with a 2-cycle reset at that cycle
    task automatic run_op(input bit sp, input int ad, input int nd, input int od, input int rst_at);
        int  acnt = 0;
        int  ncnt = 0;
        int  ocnt = 0;
        int  scnt = 0;
        int  cyc = 0;
        int  s;
        bit  started = 1'b0;
        expect_op(sp, ad, nd, od);
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            s = int'(bus.state);
            if (s != 0) started = 1'b1;
            if (s == 0 && started) break;
            if (cyc > 600) begin
                n_chk++;
                $display("FAIL op_timeout: got %0d cycles expected at most 600", cyc);
                break;
            end
            if (rst_at != 0 && cyc == rst_at) begin
                rst = 1'b1;
                bus.in_valid = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                exp_guard = 1'b0;
                break;
            end
            if (s == 2) begin
                bus.special_next = (scnt == 0) ? (sp ? rnd_non11() : 4'd11) : (sp ? 4'd11 : rnd_non11());
                scnt++;
            end else bus.special_next = 4'($urandom);
            bus.align_done = (s == 4) ? (acnt >= ad) : 1'($urandom);
            bus.norm_done  = (s == 7) ? (ncnt >= nd) : 1'($urandom);
            bus.out_ready  = (s == 11) ? (ocnt >= od) : 1'($urandom);
            bus.in_valid   = started ? 1'($urandom) : 1'b1;
            if (s == 4) acnt++;
            if (s == 7) ncnt++;
            if (s == 11) ocnt++;
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int  s;
        int  e;
        op_t o;
        forever begin
            @(negedge clk);
            if (rst_q) begin
                exp_states.delete();
                exp_ops.delete();
                in_op = 1'b0;
                chk("rst_state", 32'(bus.state), 0);
                chk("rst_out_valid", 32'(bus.out_valid), 0);
                chk("rst_in_ready", 32'(bus.in_ready), 1);
                chk("rst_guard_err", 32'(bus.guard_err), 0);
                chk("rst_last_latency", 32'(bus.last_latency), 0);
                chk("rst_z_sel", 32'(bus.z_sel_special), 0);
            end else begin
                s = int'(bus.state);
                if (s != 0) begin
                    in_op = 1'b1;
                    if (exp_states.size() == 0) chk("unexpected_state", 32'(s), 0);
                    else begin
                        e = exp_states.pop_front();
                        chk("state_seq", 32'(s), 32'(e));
                        chk("out_valid", 32'(bus.out_valid), 32'(e == 11));
                        chk("in_ready_busy", 32'(bus.in_ready), 0);
                    end
                end else begin
                    chk("idle_out_valid", 32'(bus.out_valid), 0);
                    chk("idle_in_ready", 32'(bus.in_ready), 1);
                    if (in_op) begin
                        in_op = 1'b0;
                        chk("states_left", 32'(exp_states.size()), 0);
                        if (exp_ops.size() == 0) chk("unexpected_done", 1, 0);
                        else begin
                            o = exp_ops.pop_front();
                            chk("last_latency", 32'(bus.last_latency), 32'(o.lat));
                            chk("z_sel_special", 32'(bus.z_sel_special), 32'(o.zsel));
                            chk("guard_err", 32'(bus.guard_err), 32'(o.guard));
                        end
                    end
                end
            end
        end
    end

    initial begin
        bus.in_valid     = 1'b0;
        bus.special_next = 4'd0;
        bus.align_done   = 1'b0;
        bus.norm_done    = 1'b0;
        bus.out_ready    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_op(0, 0, 0, 0, 0);
        run_op(1, 0, 0, 0, 0);
        run_op(0, 5, 3, 0, 0);
        run_op(0, 40, 0, 0, 0);
        run_op(0, 0, 0, 7, 0);
        run_op(1, 0, 0, 2, 0);
        run_op(0, 10, 0, 0, 6);
        repeat (2) @(negedge clk);
        run_op(0, 26, 26, 0, 0);
        run_op(0, 0, 27, 1, 0);
        for (int i = 0; i < 30; i++) begin
            run_op(($urandom_range(0, 3) == 0), $urandom_range(0, 30), $urandom_range(0, 30),
                   $urandom_range(0, 5), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        run_op(0, 40, 40, 200, 0);
        repeat (3) @(negedge clk);
        chk("leftover_states", 32'(exp_states.size()), 0);
        chk("leftover_ops", 32'(exp_ops.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
